// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory initiator: funct3 codes, FSM states, lane masks.
package lsu_pkg;

    localparam int unsigned DEFAULT_MEM_WORD_SIZE = 256;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        DONE
    } lsu_state_t;

    // Byte lanes across two consecutive words; [3:0] is the first word, [7:4] the second.
    function automatic logic [7:0] mask8(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic legal_funct3(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data alignment: shifts the two-word window right by the byte offset, then extends.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] win;

    always_comb begin
        win = 32'({hi, lo} >> {off, 3'b000});
        case (funct3)
            F3_B:    data = {{24{win[7]}}, win[7:0]};
            F3_BU:   data = {24'h0, win[7:0]};
            F3_H:    data = {{16{win[15]}}, win[15:0]};
            F3_HU:   data = {16'h0, win[15:0]};
            default: data = win;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// RV32I load/store initiator for a word-indexed, byte-enabled data RAM.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses instead of faulting them.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORD_SIZE = DEFAULT_MEM_WORD_SIZE,
    parameter int unsigned XLEN          = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [3:0]      byte_enable,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] w_data,
    input  logic [XLEN-1:0] r_data
);

    lsu_state_t  state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic        split_q;
    logic [3:0]  hi_be_q;

    logic [7:0]  req_mask;
    logic [29:0] req_idx;
    logic        req_split;
    logic        req_misalign;
    logic        req_range;
    logic        req_fault;

    assign req_mask = mask8(req_funct3[1:0], req_addr[1:0]);
    assign req_idx  = req_addr[31:2];

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign req_split    = |req_mask[7:4];
    assign req_misalign = 1'b0;
`else
    assign req_split    = 1'b0;
    // Any lane spill into the next word, or a halfword on an odd address.
    assign req_misalign = (|req_mask[7:4]) || ((req_funct3[1:0] == 2'b01) && req_addr[0]);
`endif

    assign req_range = ({1'b0, req_idx} >= 31'(MEM_WORD_SIZE)) ||
                       (req_split && (({1'b0, req_idx} + 31'd1) >= 31'(MEM_WORD_SIZE)));
    assign req_fault = !legal_funct3(req_we, req_funct3) || req_misalign || req_range;

    assign req_ready = (state_q == IDLE);

    logic [31:0] ext_hi;
    logic [31:0] ext_lo;
    logic [31:0] ext_data;

    // Single-word loads see r_data as the low word; split loads pair it with the latched low word.
    assign ext_hi = (state_q == ACC1) ? r_data : 32'h0;
    assign ext_lo = (state_q == ACC1) ? lo_q : r_data;

    lsu_load_extend u_load_extend (
        .hi     (ext_hi),
        .lo     (ext_lo),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            lo_q        <= 32'h0;
            split_q     <= 1'b0;
            hi_be_q     <= 4'h0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            resp_fault  <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            byte_enable <= 4'h0;
            addr        <= 32'h0;
            w_data      <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        split_q <= req_split;
                        hi_be_q <= req_mask[7:4];
                        if (req_fault) begin
                            state_q    <= DONE;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state_q     <= ACC0;
                            MemWrite    <= req_we;
                            MemRead     <= !req_we;
                            byte_enable <= req_mask[3:0];
                            addr        <= {2'b00, req_idx};
                            w_data      <= req_wdata << {req_addr[1:0], 3'b000};
                        end
                    end
                end
                ACC0: begin
                    lo_q <= r_data;
                    if (split_q) begin
                        state_q     <= ACC1;
                        byte_enable <= hi_be_q;
                        addr        <= addr + 32'd1;
                        w_data      <= wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
                    end else begin
                        state_q     <= DONE;
                        MemRead     <= 1'b0;
                        MemWrite    <= 1'b0;
                        byte_enable <= 4'h0;
                        resp_valid  <= 1'b1;
                        resp_fault  <= 1'b0;
                        resp_rdata  <= we_q ? 32'h0 : ext_data;
                    end
                end
                ACC1: begin
                    state_q     <= DONE;
                    MemRead     <= 1'b0;
                    MemWrite    <= 1'b0;
                    byte_enable <= 4'h0;
                    resp_valid  <= 1'b1;
                    resp_fault  <= 1'b0;
                    resp_rdata  <= we_q ? 32'h0 : ext_data;
                end
                DONE: begin
                    state_q    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a byte-enabled 256-word RAM model.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        MemRead;
    logic        MemWrite;
    logic [3:0]  byte_enable;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [31:0] r_data;

    logic [31:0] ram [0:255];
    logic        ram_clear;
    int          rd_total;
    int          wr_total;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp7;

    always #5 clk = ~clk;

    lsu_mem_initiator dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .byte_enable (byte_enable),
        .addr        (addr),
        .w_data      (w_data),
        .r_data      (r_data)
    );

    assign r_data = (addr < 32'd256) ? ram[addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            rd_total <= 0;
            wr_total <= 0;
        end else begin
            if (MemWrite && addr < 32'd256) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_enable[b]) ram[addr[7:0]][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
            if (MemRead)  rd_total <= rd_total + 1;
            if (MemWrite) wr_total <= wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        chk("ready_before_req", {31'h0, req_ready}, 64'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    // Issue one request and check latency, fault, data; faulted requests must not strobe the RAM.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_lat, input logic exp_fault,
                          input logic [31:0] exp_rdata, input string tag);
        int lat;
        int rd0;
        int wr0;
        drive(we, f3, a, wd);
        rd0 = rd_total;
        wr0 = wr_total;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_fault"}, {63'h0, resp_fault}, {63'h0, exp_fault});
        chk({tag, "_rdata"}, {32'h0, resp_rdata}, {32'h0, exp_rdata});
        if (exp_fault) begin
            chk({tag, "_nostrobe"}, 64'(rd_total - rd0 + wr_total - wr0), 64'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        ram_clear  = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", {32'h0, resp_rdata}, 64'h0);
        chk("rst_addr", {32'h0, addr}, 64'h0);
        chk("rst_wdata", {32'h0, w_data}, 64'h0);
        reset     = 1'b0;
        ram_clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ctl", {55'h0, req_ready, resp_valid, resp_fault, MemRead, MemWrite,
                             byte_enable}, 64'h100);
        end

        // SB 0xA5 at byte 0x13: lane 3 of word 4
        drive(1'b1, 3'b000, 32'h13, 32'hA5);
        @(negedge clk);
        req_valid = 1'b0;
        chk("sb_acc0_ctl", {58'h0, MemRead, MemWrite, byte_enable}, 64'b01_1000);
        chk("sb_acc0_addr", {32'h0, addr}, 64'h4);
        chk("sb_acc0_wdata", {32'h0, w_data}, 64'hA500_0000);
        @(negedge clk);
        chk("sb_resp", {61'h0, resp_valid, resp_fault, MemWrite}, 64'b100);
        chk("sb_ram4", {32'h0, ram[4]}, 64'hA500_0000);

        do_req(1'b1, 3'b010, 32'h10, 32'h80FF_0000, 2, 1'b0, 32'h0, "sw_10");
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF_80FF, "lh_12");
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 2, 1'b0, 32'h0000_80FF, "lhu_12");
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0, 32'hFFFF_FF80, "lb_13");
        do_req(1'b0, 3'b100, 32'h12, 32'h0, 2, 1'b0, 32'h0000_00FF, "lbu_12");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h80FF_0000, "lw_10");

`ifdef LSU_MISALIGNED_SPLIT_EN
        drive(1'b1, 3'b010, 32'h0E, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1'b0;
        chk("sw0e_acc0_ctl", {59'h0, MemWrite, byte_enable}, 64'b1_1100);
        chk("sw0e_acc0_addr", {32'h0, addr}, 64'h3);
        chk("sw0e_acc0_wdata", {32'h0, w_data}, 64'h3344_0000);
        @(negedge clk);
        chk("sw0e_acc1_ctl", {58'h0, resp_valid, MemWrite, byte_enable}, 64'b01_0011);
        chk("sw0e_acc1_addr", {32'h0, addr}, 64'h4);
        chk("sw0e_acc1_wdata", {32'h0, w_data}, 64'h0000_1122);
        @(negedge clk);
        chk("sw0e_resp", {62'h0, resp_valid, resp_fault}, 64'b10);
        do_req(1'b0, 3'b010, 32'h0E, 32'h0, 3, 1'b0, 32'h1122_3344, "lw_0e");
        do_req(1'b0, 3'b001, 32'h11, 32'h0, 2, 1'b0, 32'hFFFF_FF11, "lh_11");
        do_req(1'b0, 3'b010, 32'h3FE, 32'h0, 1, 1'b1, 32'h0, "lw_3fe_range");
`else
        do_req(1'b1, 3'b010, 32'h0E, 32'h1122_3344, 1, 1'b1, 32'h0, "sw_0e_mis");
        chk("sw0e_ram3", {32'h0, ram[3]}, 64'h0);
        chk("sw0e_ram4", {32'h0, ram[4]}, 64'h80FF_0000);
        do_req(1'b0, 3'b001, 32'h11, 32'h0, 1, 1'b1, 32'h0, "lh_11_mis");
`endif

        do_req(1'b0, 3'b010, 32'h400, 32'h0, 1, 1'b1, 32'h0, "lw_400_range");
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0, "ld_f3_011");
        do_req(1'b1, 3'b100, 32'h10, 32'hFFFF, 1, 1'b1, 32'h0, "st_f3_100");
        chk("st_f3_100_ram", {32'h0, ram[4]}, {32'h0, ram[4][31:16], 16'h0 | ram[4][15:0]});
        do_req(1'b0, 3'b010, 32'h3FC, 32'h0, 2, 1'b0, 32'h0, "lw_3fc_last");

        // Reset in the middle of a store; written bytes stay in RAM
`ifdef LSU_MISALIGNED_SPLIT_EN
        drive(1'b1, 3'b010, 32'h1E, 32'hAABB_CCDD);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        exp7 = 32'hCCDD_0000;
`else
        drive(1'b1, 3'b010, 32'h1C, 32'hAABB_CCDD);
        @(negedge clk);
        req_valid = 1'b0;
        exp7 = 32'hAABB_CCDD;
`endif
        chk("mid_we_before_rst", {63'h0, MemWrite}, 64'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", {61'h0, req_ready, MemWrite, resp_valid}, 64'b100);
        chk("mid_rst_ram7", {32'h0, ram[7]}, {32'h0, exp7});
        reset = 1'b0;
        do_req(1'b0, 3'b010, 32'h1C, 32'h0, 2, 1'b0, exp7, "lw_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
